// File: rtl/rom_ctrl_scr_fetch.sv
// rom_ctrl_scr_fetch
//   Read initiator for the scrambled ROM. A start pulse launches one sweep over
//   ROM addresses 0..Depth-1 in order. Every returned word is buffered, with
//   its issue-order address, in a small credit-limited FIFO. The FIFO streams
//   {addr, scrambled, clear} words to a consumer over valid/ready. A counter
//   divergence or an unrequested response sets a sticky error.
//
// Ports
//   clk_i, rst_ni        clock, synchronous active-low reset
//   start_i              begin a sweep (honoured in IDLE/DONE only)
//   busy_o, done_o       sweep in progress / sweep complete and fully consumed
//   err_o                sticky fault, cleared only by reset
//   rom_req_o            read request; rom_addr_o (counter A), prince_addr_o (counter B)
//   rom_rvalid_i         response valid with rom_scr_rdata_i / rom_clr_rdata_i
//   data_valid_o/ready_i head-of-FIFO handshake
//   data_addr_o/scr_o/clr_o head word fields (zero while empty)
module rom_ctrl_scr_fetch #(
   parameter int Width      = 40,
   parameter int Depth      = 16,
   parameter int RomLatency = 1,
   parameter int FifoDepth  = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o,
   output logic                     rom_req_o,
   output logic [$clog2(Depth)-1:0] rom_addr_o,
   output logic [$clog2(Depth)-1:0] prince_addr_o,
   input  logic                     rom_rvalid_i,
   input  logic [Width-1:0]         rom_scr_rdata_i,
   input  logic [Width-1:0]         rom_clr_rdata_i,
   output logic                     data_valid_o,
   input  logic                     data_ready_i,
   output logic [$clog2(Depth)-1:0] data_addr_o,
   output logic [Width-1:0]         data_scr_o,
   output logic [Width-1:0]         data_clr_o
);

   localparam int Aw = $clog2(Depth);
   localparam int Cw = $clog2(FifoDepth + 1);
   localparam int Pw = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam int Ew = Aw + 2 * Width;
   localparam logic [Cw:0]   CreditMax = (Cw + 1)'(FifoDepth);
   localparam logic [Cw-1:0] MaxOut    = Cw'(RomLatency);
   localparam logic [Aw-1:0] LastAddr  = Aw'(Depth - 1);

   typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_DRAIN, ST_DONE, ST_ERROR} state_e;

   state_e        state_q, state_d;
   logic [Aw-1:0] cnt_a, cnt_b;
   logic [Cw-1:0] out_cnt, fifo_cnt;
   logic [Pw-1:0] tag_wr, tag_rd, dat_wr, dat_rd;
   logic [Aw-1:0] tag_mem [FifoDepth];
   logic [Ew-1:0] dat_mem [FifoDepth];
   logic [Ew-1:0] head;
   logic [Cw:0]   credit_used;
   logic          start_ok, take, push, pop, fault, flush, last_req;

   function automatic logic [Pw-1:0] nxt_ptr(input logic [Pw-1:0] p);
      return (p == Pw'(FifoDepth - 1)) ? '0 : p + Pw'(1);
   endfunction

   assign start_ok = start_i && (state_q == ST_IDLE || state_q == ST_DONE);
   assign pop      = (fifo_cnt != '0) && (state_q != ST_ERROR) && data_ready_i;
   assign take     = rom_rvalid_i && (out_cnt != '0);
   assign fault    = (state_q != ST_ERROR) &&
                     ((cnt_a != cnt_b) || (rom_rvalid_i && out_cnt == '0) || (out_cnt > MaxOut));
   assign push     = take && !fault;
   assign flush    = fault || (state_q == ST_ERROR) || start_ok;
   assign last_req = rom_req_o && (cnt_a == LastAddr);

   // A word leaving the FIFO this cycle frees its slot at this edge, and the
   // earliest response to a new request lands one edge later. Counting the pop
   // as returned credit keeps one request per cycle when the consumer is ready.
   assign credit_used = {1'b0, out_cnt} + {1'b0, fifo_cnt} - {{Cw{1'b0}}, pop};

   // NOTE: sequential state uses non-blocking assignments; combinational logic uses blocking.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      state_d = state_q;
      if (fault) begin
         state_d = ST_ERROR;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_DONE: if (start_i) state_d = ST_FETCH;
            ST_FETCH:         if (last_req) state_d = ST_DRAIN;
            // Leave as soon as the final word is being consumed.
            ST_DRAIN: if (out_cnt == '0 && (fifo_cnt == '0 || (fifo_cnt == Cw'(1) && pop)))
                         state_d = ST_DONE;
            default:          state_d = state_q;
         endcase
      end
   end

   always_comb begin
      rom_req_o = 1'b0;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      err_o     = 1'b0;
      unique case (state_q)
         ST_FETCH: begin
            busy_o    = 1'b1;
            rom_req_o = credit_used < CreditMax;
         end
         ST_DRAIN: busy_o = 1'b1;
         ST_DONE:  done_o = !start_i;
         ST_ERROR: err_o  = 1'b1;
         default:  ;
      endcase
   end

   // Two independent address counters; they never wrap during a sweep.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_a <= '0;
         cnt_b <= '0;
      end else if (start_ok) begin
         cnt_a <= '0;
         cnt_b <= '0;
      end else if (rom_req_o && !last_req) begin
         cnt_a <= cnt_a + Aw'(1);
         cnt_b <= cnt_b + Aw'(1);
      end
   end

   // Outstanding reads and their issue-order address tags.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         out_cnt <= '0;
         tag_wr  <= '0;
         tag_rd  <= '0;
      end else if (flush) begin
         out_cnt <= '0;
         tag_wr  <= '0;
         tag_rd  <= '0;
      end else begin
         if (rom_req_o) tag_wr <= nxt_ptr(tag_wr);
         if (take)      tag_rd <= nxt_ptr(tag_rd);
         unique case ({rom_req_o, take})
            2'b10:   out_cnt <= out_cnt + Cw'(1);
            2'b01:   out_cnt <= out_cnt - Cw'(1);
            default: out_cnt <= out_cnt;
         endcase
      end
   end

   // NOTE: storage arrays carry no reset; the pointers and counts say which entries are live.
   always_ff @(posedge clk_i) begin
      if (rom_req_o) tag_mem[tag_wr] <= cnt_a;
      if (push)      dat_mem[dat_wr] <= {tag_mem[tag_rd], rom_scr_rdata_i, rom_clr_rdata_i};
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         fifo_cnt <= '0;
         dat_wr   <= '0;
         dat_rd   <= '0;
      end else if (flush) begin
         fifo_cnt <= '0;
         dat_wr   <= '0;
         dat_rd   <= '0;
      end else begin
         if (push) dat_wr <= nxt_ptr(dat_wr);
         if (pop)  dat_rd <= nxt_ptr(dat_rd);
         unique case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + Cw'(1);
            2'b01:   fifo_cnt <= fifo_cnt - Cw'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   assign rom_addr_o    = cnt_a;
   assign prince_addr_o = cnt_b;
   assign data_valid_o  = (fifo_cnt != '0) && (state_q != ST_ERROR);
   assign head          = data_valid_o ? dat_mem[dat_rd] : '0;
   assign data_addr_o   = head[Ew-1 -: Aw];
   assign data_scr_o    = head[2*Width-1 -: Width];
   assign data_clr_o    = head[Width-1:0];

endmodule

// File: tb/tb_rom_ctrl_scr_fetch.sv
// tb_rom_ctrl_scr_fetch
//   Scenario tasks drive a rom_ctrl_scr_fetch instance. A one-cycle-latency ROM
//   model answers every accepted request from a randomly filled table. Expected
//   traffic per sweep is plain data: requests 0..Depth-1 and delivered words
//   matching the table, in order.
module tb_rom_ctrl_scr_fetch;

   localparam int Width      = 40;
   localparam int Depth      = 16;
   localparam int RomLatency = 1;
   localparam int FifoDepth  = 2;
   localparam int Aw         = $clog2(Depth);
   localparam int SweepCyc   = Depth + RomLatency + 2;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic             start_i = 1'b0;
   logic             data_ready_i = 1'b0;
   logic             rsp_valid = 1'b0;
   logic             stray_rvalid = 1'b0;
   logic             rom_rvalid_i;
   logic [Width-1:0] rom_scr_rdata_i = '0;
   logic [Width-1:0] rom_clr_rdata_i = '0;
   logic             busy_o, done_o, err_o, rom_req_o, data_valid_o;
   logic [Aw-1:0]    rom_addr_o, prince_addr_o, data_addr_o;
   logic [Width-1:0] data_scr_o, data_clr_o;
   logic [4+3*Aw+2*Width:0] all_out;

   assign rom_rvalid_i = rsp_valid | stray_rvalid;
   assign all_out = {busy_o, done_o, err_o, rom_req_o, rom_addr_o, prince_addr_o,
                     data_valid_o, data_addr_o, data_scr_o, data_clr_o};

   rom_ctrl_scr_fetch #(.Width(Width), .Depth(Depth), .RomLatency(RomLatency), .FifoDepth(FifoDepth)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
      .err_o(err_o), .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .prince_addr_o(prince_addr_o),
      .rom_rvalid_i(rom_rvalid_i), .rom_scr_rdata_i(rom_scr_rdata_i), .rom_clr_rdata_i(rom_clr_rdata_i),
      .data_valid_o(data_valid_o), .data_ready_i(data_ready_i), .data_addr_o(data_addr_o),
      .data_scr_o(data_scr_o), .data_clr_o(data_clr_o)
   );

   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;
   logic [Width-1:0] scr_tab [Depth];
   logic [Width-1:0] clr_tab [Depth];

   // ROM model: a request seen mid-cycle is accepted at the next edge unless
   // that edge is a reset edge, and answered one cycle later.
   initial begin : rom_model
      logic          r_req;
      logic [Aw-1:0] r_addr;
      logic          acc;
      forever begin
         @(negedge clk_i);
         r_req  = rom_req_o;
         r_addr = rom_addr_o;
         @(posedge clk_i);
         acc = r_req && rst_ni;
         #1;
         rsp_valid       = acc;
         rom_scr_rdata_i = acc ? scr_tab[r_addr] : '0;
         rom_clr_rdata_i = acc ? clr_tab[r_addr] : '0;
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic fill_rom();
      for (int i = 0; i < Depth; i++) begin
         scr_tab[i] = Width'({$urandom(), $urandom()});
         clr_tab[i] = Width'({$urandom(), $urandom()});
      end
   endtask

   // Every task starts and ends one time unit after a rising edge.
   task automatic apply_reset(input int cycles);
      rst_ni = 1'b0;
      start_i = 1'b0;
      stray_rvalid = 1'b0;
      repeat (cycles) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
   endtask

   task automatic test_reset();
      data_ready_i = 1'b1;
      rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      n_tests++;
      if (all_out !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %0h expected 0", all_out);
      end
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      @(negedge clk_i);
      n_tests++;
      if (all_out !== '0) begin
         n_fail++;
         $display("FAIL idle_outputs: got %0h expected 0", all_out);
      end
      @(posedge clk_i); #1;
   endtask

   // One full sweep. hold: cycles with ready low after start; pct: ready
   // probability afterwards; timed: also check exact request and done timing.
   task automatic do_sweep(input string tag, input int hold, input int pct, input bit timed);
      int req_idx = 0;
      int rx_idx = 0;
      int done_cyc = -1;
      bit held = 1'b0;
      logic [Aw+2*Width-1:0] held_word = '0;
      logic [Aw+2*Width-1:0] cur;
      fill_rom();
      start_i = 1'b1;
      data_ready_i = 1'b0;
      @(negedge clk_i);
      n_tests++;
      if (done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL %s done_drop: got %b expected 0", tag, done_o);
      end
      @(posedge clk_i); #1;
      start_i = 1'b0;
      for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
         data_ready_i = (cyc <= hold) ? 1'b0 : (($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0);
         @(negedge clk_i);
         cur = {data_addr_o, data_scr_o, data_clr_o};
         if (timed) begin
            n_tests++;
            if (rom_req_o !== (cyc <= Depth)) begin
               n_fail++;
               $display("FAIL %s req_timing cyc %0d: got %b expected %b", tag, cyc, rom_req_o, cyc <= Depth);
            end
         end
         if (rom_req_o === 1'b1) begin
            n_tests++;
            if (req_idx >= Depth || rom_addr_o !== Aw'(req_idx) || prince_addr_o !== Aw'(req_idx)) begin
               n_fail++;
               $display("FAIL %s req_addr: got %0d/%0d expected %0d", tag, rom_addr_o, prince_addr_o, req_idx);
            end
            req_idx++;
         end
         if (hold > 0 && cyc == hold) begin
            n_tests++;
            if (req_idx != FifoDepth || rom_req_o !== 1'b0) begin
               n_fail++;
               $display("FAIL %s credit_stall: got %0d reqs req=%b expected %0d reqs req=0",
                        tag, req_idx, rom_req_o, FifoDepth);
            end
         end
         if (held) begin
            n_tests++;
            if (data_valid_o !== 1'b1 || cur !== held_word) begin
               n_fail++;
               $display("FAIL %s stable_head: got v=%b %0h expected v=1 %0h", tag, data_valid_o, cur, held_word);
            end
         end
         held = 1'b0;
         if (data_valid_o === 1'b1) begin
            if (data_ready_i) begin
               n_tests++;
               if (rx_idx >= Depth || cur !== {Aw'(rx_idx), scr_tab[rx_idx % Depth], clr_tab[rx_idx % Depth]}) begin
                  n_fail++;
                  $display("FAIL %s word %0d: got %0h expected addr %0d scr %0h clr %0h",
                           tag, rx_idx, cur, rx_idx, scr_tab[rx_idx % Depth], clr_tab[rx_idx % Depth]);
               end
               rx_idx++;
            end else begin
               held = 1'b1;
               held_word = cur;
            end
         end
         if (done_o === 1'b1) done_cyc = cyc;
         @(posedge clk_i); #1;
      end
      n_tests++;
      if (done_cyc < 0) begin
         n_fail++;
         $display("FAIL %s done_timeout: got no done expected done within 400 cycles", tag);
      end else if (timed && done_cyc != SweepCyc) begin
         n_fail++;
         $display("FAIL %s done_cycle: got %0d expected %0d", tag, done_cyc, SweepCyc);
      end
      n_tests++;
      if (req_idx != Depth || rx_idx != Depth) begin
         n_fail++;
         $display("FAIL %s counts: got %0d reqs %0d words expected %0d", tag, req_idx, rx_idx, Depth);
      end
      @(negedge clk_i);
      n_tests++;
      if ({done_o, busy_o, err_o, data_valid_o} !== 4'b1000) begin
         n_fail++;
         $display("FAIL %s end_state: got done/busy/err/valid %b expected 1000",
                  tag, {done_o, busy_o, err_o, data_valid_o});
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_full_sweep();
      do_sweep("sweep", 0, 100, 1'b1);
   endtask

   task automatic test_back_to_back();
      do_sweep("restart_a", 0, 100, 1'b1);
      do_sweep("restart_b", 0, 100, 1'b1);
   endtask

   task automatic test_backpressure();
      do_sweep("backpressure", 8, 100, 1'b0);
   endtask

   task automatic test_random_ready();
      do_sweep("rand_ready_60", 0, 60, 1'b0);
      do_sweep("rand_ready_25", 3, 25, 1'b0);
   endtask

   task automatic test_stray_rvalid();
      apply_reset(1);
      @(negedge clk_i);
      n_tests++;
      if (err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL stray_pre_err: got %b expected 0", err_o);
      end
      @(posedge clk_i); #1;
      stray_rvalid = 1'b1;
      @(posedge clk_i); #1;
      stray_rvalid = 1'b0;
      @(negedge clk_i);
      n_tests++;
      if (err_o !== 1'b1) begin
         n_fail++;
         $display("FAIL stray_err: got %b expected 1", err_o);
      end
      @(posedge clk_i); #1;
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         n_tests++;
         if ({busy_o, rom_req_o, err_o, done_o} !== 4'b0010) begin
            n_fail++;
            $display("FAIL stray_start_ignored: got busy/req/err/done %b expected 0010",
                     {busy_o, rom_req_o, err_o, done_o});
         end
         @(posedge clk_i); #1;
      end
   endtask

   // Runs a sweep until the request for addr is visible; ends at that negedge.
   task automatic run_until_addr(input string tag, input int addr);
      bit found = 1'b0;
      fill_rom();
      data_ready_i = 1'b1;
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk_i);
         if (rom_req_o === 1'b1 && rom_addr_o === Aw'(addr)) found = 1'b1;
         else begin
            @(posedge clk_i); #1;
         end
      end
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL %s reach_addr: got no req at %0d expected one within 60 cycles", tag, addr);
      end
   endtask

   task automatic test_counter_diverge();
      apply_reset(1);
      run_until_addr("diverge", 4);
      force dut.cnt_b = 4'd5;
      @(posedge clk_i); #1;
      release dut.cnt_b;
      @(negedge clk_i);
      n_tests++;
      if ({err_o, rom_req_o, data_valid_o, busy_o} !== 4'b1000) begin
         n_fail++;
         $display("FAIL diverge_err: got err/req/valid/busy %b expected 1000",
                  {err_o, rom_req_o, data_valid_o, busy_o});
      end
      @(posedge clk_i); #1;
      apply_reset(1);
   endtask

   task automatic test_reset_mid_sweep();
      run_until_addr("midreset", 7);
      rst_ni = 1'b0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      @(negedge clk_i);
      n_tests++;
      if (all_out !== '0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got %0h expected 0", all_out);
      end
      @(posedge clk_i); #1;
      do_sweep("after_reset", 0, 100, 1'b1);
   endtask

   initial begin
      test_reset();
      test_full_sweep();
      test_back_to_back();
      test_backpressure();
      test_random_ready();
      test_stray_rvalid();
      test_counter_diverge();
      test_reset_mid_sweep();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
